// File: rtl/ir_frame_receiver.sv
// RZ IR frame receiver: start, 7 data bits LSB-first, odd parity, stop.
// A pulse (rx high) anywhere in a bit window decodes as 0; delivery uses a level-valid/ack handshake.
module ir_frame_receiver #(
  parameter int BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pulse,
  input  logic       rx_ack,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(BIT_CLKS);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state;
  logic          rx_m, rx_s, rx_s_d;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic          seen;
  logic [7:0]    shreg;
  logic          win_end, bit_val, done, ack;

  assign win_end = (state == RECV) && (clk_cnt == CW'(BIT_CLKS - 1));
  assign bit_val = ~(seen | rx_s);
  assign done    = win_end && (bit_idx == 4'd9);
  assign ack     = rx_ack && data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m   <= 1'b0;
      rx_s   <= 1'b0;
      rx_s_d <= 1'b0;
    end else begin
      rx_m   <= rx_pulse;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      seen       <= 1'b0;
      shreg      <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Edge-triggered start so a line stuck high cannot retrigger.
          if (rx_s && !rx_s_d) begin
            state   <= RECV;
            clk_cnt <= '0;
            bit_idx <= '0;
            seen    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RECV: begin
          if (win_end) begin
            seen    <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            // Data then parity shift in from the top; after 8 windows shreg = {parity, data}.
            if (bit_idx >= 4'd1 && bit_idx <= 4'd8)
              shreg <= {bit_val, shreg[7:1]};
            if (done) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_idx <= '0;
            end
          end else begin
            seen    <= seen | rx_s;
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        data_out   <= shreg[6:0];
        parity_err <= ~(^shreg);
        frame_err  <= ~bit_val;
        data_valid <= 1'b1;
        if (ack)
          overrun <= 1'b0;
        else if (data_valid)
          overrun <= 1'b1;
      end else if (ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ir_frame_receiver.sv
// Bench for ir_frame_receiver: table of frames driven through an RZ transmitter model,
// expected results queued at send time and checked when busy falls.
module tb_ir_frame_receiver;
  localparam int BIT_CLKS = 16;
  localparam int GAP      = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pulse = 1'b0;
  logic       rx_ack = 1'b0;
  logic [6:0] data_out;
  logic       data_valid, parity_err, frame_err, overrun, busy;

  ir_frame_receiver #(.BIT_CLKS(BIT_CLKS)) dut (
    .clk(clk), .rst(rst), .rx_pulse(rx_pulse), .rx_ack(rx_ack),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] d;
    logic       perr, ferr, ovr;
  } exp_t;

  typedef struct {
    logic [6:0] d;
    logic       par, stop_pulse, ack_cmp, ack_after;
    logic       perr, ferr, ovr;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_start = 0;
  bit   busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Completion is observed as busy falling outside reset.
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_q = 1'b0;
    else begin
      if (busy && !busy_q) t_start = cyc;
      if (!busy && busy_q) begin
        if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("parity_err", 32'(parity_err), 32'(e.perr));
          chk("frame_err", 32'(frame_err), 32'(e.ferr));
          chk("overrun", 32'(overrun), 32'(e.ovr));
          chk("data_valid", 32'(data_valid), 32'd1);
          chk("latency", 32'(cyc - t_start), 32'(10 * BIT_CLKS));
        end
      end
      busy_q = busy;
    end
  end

  // Receiver windows lag the line by the sync/detect latency, so data pulses sit 2 clk into each window.
  task automatic tx(input logic [9:0] bits, input int nwin, input int gap, input logic ack_cmp);
    for (int c = 0; c < nwin * BIT_CLKS + gap; c++) begin
      int w, o, off;
      w   = c / BIT_CLKS;
      o   = c % BIT_CLKS;
      off = (w == 0) ? 0 : 2;
      rx_pulse = (w < nwin) && !bits[w] && (o >= off) && (o < off + 3);
      rx_ack   = ack_cmp && (c == 10 * BIT_CLKS + 2);
      @(posedge clk); #1;
    end
    rx_pulse = 1'b0;
    rx_ack   = 1'b0;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  function automatic logic [9:0] mkbits(input logic [6:0] d, input logic par, input logic stop_pulse);
    return {~stop_pulse, par, d, 1'b0};
  endfunction

  initial begin
    //         d      par   stop  ackc  ackaf perr  ferr  ovr
    vt[0] = '{7'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{7'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{7'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{7'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{7'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{7'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{7'h6C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{7'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{7'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vt[i].d, vt[i].perr, vt[i].ferr, vt[i].ovr});
      tx(mkbits(vt[i].d, vt[i].par, vt[i].stop_pulse), 10, GAP, vt[i].ack_cmp);
      if (vt[i].ack_after) begin
        do_ack();
        chk("ack_valid_clr", 32'(data_valid), 32'd0);
        chk("ack_ovr_clr", 32'(overrun), 32'd0);
        do_ack();
        chk("idle_ack_data_hold", 32'(data_out), 32'(vt[i].d));
        chk("idle_ack_perr_hold", 32'(parity_err), 32'(vt[i].perr));
        chk("idle_ack_valid", 32'(data_valid), 32'd0);
      end
    end

    // Reset at bit_idx=4 with data_valid/overrun set from the last table frame.
    tx(mkbits(7'h2A, 1'b0, 1'b0), 4, 6, 1'b0);
    chk("busy_midframe", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_data_valid", 32'(data_valid), 32'd0);
    chk("midrst_parity_err", 32'(parity_err), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    sb.push_back('{7'h2A, 1'b0, 1'b0, 1'b0});
    tx(mkbits(7'h2A, 1'b0, 1'b0), 10, GAP, 1'b0);

    // Line stuck high: one frame of all-zero windows, then no retrigger.
    sb.push_back('{7'h00, 1'b1, 1'b1, 1'b1});
    rx_pulse = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
    end
    chk("stuck_no_retrigger", 32'(busy), 32'd0);
    rx_pulse = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
